oam_dma: RTL and testbench

- Sprite-OAM DMA engine for the 2A03 core. It sits beside cpu_2a03 on the CPU-side bus, between the CPU and the shared memory/PPU bus.
- A CPU write to $4014 with page value P makes the block halt the CPU and take the bus. It then copies 256 bytes from $PP00-$PPFF to the OAM data port ($2004) as read/write pairs, and returns the bus to the CPU.
- A top-level mux selects dma_* over the CPU's addr/data_out/rw whenever dma_active=1.

---
 rtl/oam_dma.sv | 127 ++++++++++++
 tb/tb_oam_dma.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite-OAM DMA engine: a write to DMA_REG_ADDR halts the CPU and copies one
// 256-byte page to the OAM data port as read/write pairs.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter bit          ALIGN_EN      = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw,
    input  logic [7:0]  mem_data_in,
    output logic        cpu_halt,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_data_out,
    output logic        dma_done
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam logic [DATA_W-1:0] LAST_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   page, page_nx;
    logic [DATA_W-1:0]   count, count_nx;
    logic [DATA_W-1:0]   latch, latch_nx;
    logic                phase;
    logic                done_nx;
    logic                halt_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic                rw_nx;
    logic [DATA_W-1:0]   data_nx;

    // Next-state logic; outputs are derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_nx = state;
        page_nx  = page;
        count_nx = count;
        latch_nx = latch;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (!cpu_rw && cpu_addr == DMA_REG_ADDR) begin
                    page_nx  = cpu_data_out;
                    count_nx = '0;
                    state_nx = HALT;
                end
            end
            HALT: begin
                // Next cycle's phase is ~phase; align when that would be a put cycle.
                state_nx = (ALIGN_EN && !phase) ? ALIGN : READ;
            end
            ALIGN: begin
                state_nx = READ;
            end
            READ: begin
                latch_nx = mem_data_in;
                state_nx = WRITE;
            end
            WRITE: begin
                if (count == LAST_BYTE) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    count_nx = count + DATA_W'(1);
                    state_nx = READ;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        halt_nx = (state_nx != IDLE);
        rw_nx   = (state_nx != WRITE);
        data_nx = (state_nx == WRITE) ? latch_nx : '0;
        case (state_nx)
            HALT, ALIGN: addr_nx = {page_nx, 8'h00};
            READ:        addr_nx = {page_nx, count_nx};
            WRITE:       addr_nx = OAM_DATA_ADDR;
            default:     addr_nx = '0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            page         <= '0;
            count        <= '0;
            latch        <= '0;
            phase        <= 1'b0;
            dma_done     <= 1'b0;
            cpu_halt     <= 1'b0;
            dma_active   <= 1'b0;
            dma_addr     <= '0;
            dma_rw       <= 1'b1;
            dma_data_out <= '0;
        end else begin
            state        <= state_nx;
            page         <= page_nx;
            count        <= count_nx;
            latch        <= latch_nx;
            phase        <= ~phase;
            dma_done     <= done_nx;
            cpu_halt     <= halt_nx;
            dma_active   <= halt_nx;
            dma_addr     <= addr_nx;
            dma_rw       <= rw_nx;
            dma_data_out <= data_nx;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: cycle-by-cycle compare of the bus outputs
// against hand-derived transfer sequences.
module tb_oam_dma;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic [7:0]  mem_data_in;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_data_out;
    logic        dma_done;

    always #5 clock = ~clock;

    oam_dma dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_rw       (cpu_rw),
        .mem_data_in  (mem_data_in),
        .cpu_halt     (cpu_halt),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .dma_rw       (dma_rw),
        .dma_data_out (dma_data_out),
        .dma_done     (dma_done)
    );

    logic [7:0] mem [0:65535];
    assign mem_data_in = mem[dma_addr];

    logic [31:0] obs;
    assign obs = {4'h0, cpu_halt, dma_active, dma_rw, dma_done, dma_addr, dma_data_out};

    // Independent phase model: 0 in the first cycle after reset, then toggles.
    logic tb_phase;
    always @(posedge clock) tb_phase <= reset ? 1'b0 : ~tb_phase;

    int tests = 0;
    int fails = 0;
    logic [7:0] first_wd, last_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vec(input logic h, input logic a, input logic rw,
                                        input logic d, input logic [15:0] ad,
                                        input logic [7:0] dt);
        return {4'h0, h, a, rw, d, ad, dt};
    endfunction

    localparam logic [31:0] IDLE_V = {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00};

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_idle();
        cpu_addr     = 16'h0000;
        cpu_rw       = 1'b1;
        cpu_data_out = 8'h00;
    endtask

    task automatic wait_phase(input logic b);
        for (int k = 0; k < 2 && tb_phase != b; k++) next_cycle();
    endtask

    task automatic do_trigger(input logic [7:0] p);
        cpu_addr     = 16'h4014;
        cpu_rw       = 1'b0;
        cpu_data_out = p;
        @(negedge clock);
        check("trigger_cycle_idle", obs, IDLE_V);
        next_cycle();
        bus_idle();
    endtask

    // Checks every cycle from HALT through the done pulse.
    task automatic run_xfer(input string tag, input logic [7:0] p, input int align,
                            input bit inject);
        int          halt_n = 0;
        int          total  = 1 + align + 512;
        logic [31:0] e;
        logic [7:0]  i8;
        for (int c = 0; c < total; c++) begin
            if (inject && c == 10) begin
                cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h07;
            end else begin
                bus_idle();
            end
            if (c <= align) begin
                e = vec(1'b1, 1'b1, 1'b1, 1'b0, {p, 8'h00}, 8'h00);
            end else begin
                i8 = 8'((c - 1 - align) / 2);
                if (((c - 1 - align) % 2) == 0)
                    e = vec(1'b1, 1'b1, 1'b1, 1'b0, {p, i8}, 8'h00);
                else
                    e = vec(1'b1, 1'b1, 1'b0, 1'b0, 16'h2004, mem[{p, i8}]);
            end
            @(negedge clock);
            check($sformatf("%s_c%0d", tag, c + 1), obs, e);
            if (cpu_halt) halt_n++;
            if (!dma_rw && c == 2 + align) first_wd = dma_data_out;
            if (!dma_rw) last_wd = dma_data_out;
            next_cycle();
        end
        bus_idle();
        @(negedge clock);
        check({tag, "_done_pulse"}, obs, vec(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00));
        next_cycle();
        @(negedge clock);
        check({tag, "_done_clear"}, obs, IDLE_V);
        check({tag, "_halt_len"}, 32'(halt_n), 32'(513 + align));
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int al;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
        for (int a = 16'h0300; a < 16'h0400; a++) mem[a] = 8'(a) ^ 8'hA5;

        reset = 1'b1;
        bus_idle();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_state", obs, IDLE_V);
        next_cycle();

        // HALT on phase 1: no alignment, 513 halt cycles.
        wait_phase(1'b0);
        do_trigger(8'h02);
        run_xfer("page02", 8'h02, 0, 1'b0);

        // HALT on phase 0: one ALIGN cycle, first read at cycle 3.
        wait_phase(1'b1);
        do_trigger(8'h02);
        run_xfer("page02_align", 8'h02, 1, 1'b0);

        // Preloaded page $03: write data runs $A5 down to $5A.
        al = int'(tb_phase);
        do_trigger(8'h03);
        run_xfer("page03", 8'h03, al, 1'b0);
        check("page03_first_wd", 32'(first_wd), 32'h0000_00A5);
        check("page03_last_wd", 32'(last_wd), 32'h0000_005A);

        // Second trigger write during an active DMA is ignored.
        al = int'(tb_phase);
        do_trigger(8'h02);
        run_xfer("inject07", 8'h02, al, 1'b1);

        // Reset on the 100th READ abandons the transfer.
        al = int'(tb_phase);
        do_trigger(8'h02);
        repeat (1 + al + 198) next_cycle();
        @(negedge clock);
        check("read100", obs, vec(1'b1, 1'b1, 1'b1, 1'b0, 16'h0263, 8'h00));
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("abort_reset", obs, IDLE_V);
        next_cycle();
        al = int'(tb_phase);
        do_trigger(8'h04);
        run_xfer("page04", 8'h04, al, 1'b0);

        // Read of $4014 and write to $4015 must not trigger.
        cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_data_out = 8'h05;
        @(negedge clock);
        check("rd4014_cycle", obs, IDLE_V);
        next_cycle();
        cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_data_out = 8'h05;
        @(negedge clock);
        check("rd4014_after", obs, IDLE_V);
        next_cycle();
        bus_idle();
        @(negedge clock);
        check("wr4015_after", obs, IDLE_V);
        next_cycle();
        @(negedge clock);
        check("still_idle", obs, IDLE_V);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
